rnd_chk_m: RTL and testbench

Synthesizable PRBS checker, the receive end of the team's XNOR-LFSR random generator. It consumes a serial bit stream produced by a generator built with the same `rndgen_pkg` parameter set, self-synchronizes to it, then free-runs a local LFSR and counts bit errors. It sits at the far side of links, SERDES loopbacks and memory test paths as the pass/fail monitor.

---
 rtl/rndgen_pkg.sv | 20 ++
 rtl/rnd_chk_m.sv | 185 ++++++++++++++++++
 tb/tb_rnd_chk_m.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/rndgen_pkg.sv
// Parameter sets shared by the XNOR-LFSR random generator and its checker.
package rndgen_pkg;

  // TapeNum is the register length; FB is a zero-terminated tap list,
  // FB[0] first.
  typedef struct packed {
    int unsigned        TapeNum;
    logic [7:0][7:0]    FB;
  } RndGenParams_t;

  localparam RndGenParams_t RndGen7  = '{TapeNum: 32'd7,
    FB: {8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd6, 8'd7}};
  localparam RndGenParams_t RndGen15 = '{TapeNum: 32'd15,
    FB: {8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd14, 8'd15}};
  localparam RndGenParams_t RndGen23 = '{TapeNum: 32'd23,
    FB: {8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd18, 8'd23}};
  localparam RndGenParams_t RndGen31 = '{TapeNum: 32'd31,
    FB: {8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd28, 8'd31}};

endpackage

// File: rtl/rnd_chk_m.sv
// PRBS checker for the XNOR-LFSR generator: self-synchronises on the
// received stream, then free-runs a local LFSR and counts bit errors.
module rnd_chk_m #(
  parameter rndgen_pkg::RndGenParams_t PARAMS = rndgen_pkg::RndGen31,
  parameter int LOCK_CNT   = 64,
  parameter int WIN_LEN    = 256,
  parameter int UNLOCK_THR = 16,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in,
  input  logic             clr,
  output logic             locked,
  output logic             err,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] bit_cnt
);

  localparam int N  = int'(PARAMS.TapeNum);
  localparam int FW = $clog2(N + 1);
  localparam int MW = $clog2(LOCK_CNT + 1);
  localparam int WW = $clog2(WIN_LEN + 1);
  localparam int EW = $clog2(UNLOCK_THR + 1);

  localparam logic [FW-1:0] FILL_LAST  = FW'(N - 1);
  localparam logic [MW-1:0] MATCH_LAST = MW'(LOCK_CNT - 1);
  localparam logic [WW-1:0] WIN_LAST   = WW'(WIN_LEN - 1);
  localparam logic [EW-1:0] ERR_LAST   = EW'(UNLOCK_THR - 1);

  // Tap positions as a mask over h[1:N], up to the first zero entry.
  function automatic logic [N:1] tap_mask_f();
    logic [N:1] m;
    logic       done;
    m    = '0;
    done = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (PARAMS.FB[i] == 8'd0) done = 1'b1;
      for (int k = 1; k <= N; k++)
        if (!done && PARAMS.FB[i] == 8'(k)) m[k] = 1'b1;
    end
    return m;
  endfunction

  localparam logic [N:1] TAP_MASK = tap_mask_f();
  // A 1-seeded XNOR chain equals parity for odd tap counts and inverted
  // parity for even ones.
  localparam logic       TAP_INV  = ~(^TAP_MASK);

  // Saturating statistics counter; a clear that coincides with an event
  // leaves the count at one.
  function automatic logic [CNT_W-1:0] stat_next(input logic [CNT_W-1:0] cur,
                                                 input logic clr_i,
                                                 input logic ev);
    if (clr_i)             return ev ? CNT_W'(1) : '0;
    else if (ev && ~&cur)  return cur + 1'b1;
    else                   return cur;
  endfunction

  typedef enum logic [1:0] {S_FILL, S_HUNT, S_LOCKED} state_t;

  state_t           state_q, state_d;
  logic [N:1]       h_q, h_d;
  logic [FW-1:0]    fill_q, fill_d;
  logic [MW-1:0]    match_q, match_d;
  logic [WW-1:0]    win_q, win_d;
  logic [EW-1:0]    werr_q, werr_d;
  logic             pred;
  logic             miss;
  logic             chk_ev;

  logic             locked_q, locked_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;

  // State register with history and synchronisation/window counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FILL;
      h_q     <= '0;
      fill_q  <= '0;
      match_q <= '0;
      win_q   <= '0;
      werr_q  <= '0;
    end else begin
      state_q <= state_d;
      h_q     <= h_d;
      fill_q  <= fill_d;
      match_q <= match_d;
      win_q   <= win_d;
      werr_q  <= werr_d;
    end
  end

  // Next-state: fill history, hunt for LOCK_CNT consecutive matches, then
  // free-run on the predicted bit and watch the per-window error count.
  always_comb begin
    state_d = state_q;
    h_d     = h_q;
    fill_d  = fill_q;
    match_d = match_q;
    win_d   = win_q;
    werr_d  = werr_q;
    miss    = 1'b0;
    chk_ev  = 1'b0;
    pred    = (^(h_q & TAP_MASK)) ^ TAP_INV;
    if (in_valid) begin
      case (state_q)
        S_FILL: begin
          h_d = {h_q[N-1:1], in};
          if (fill_q == FILL_LAST) begin
            fill_d  = '0;
            state_d = S_HUNT;
          end else begin
            fill_d = fill_q + 1'b1;
          end
        end
        S_HUNT: begin
          h_d = {h_q[N-1:1], in};
          if (in != pred) begin
            match_d = '0;
          end else if (match_q == MATCH_LAST) begin
            // An all-ones history is the XNOR lockup a stuck-high line
            // would self-match, so it never counts as lock.
            match_d = '0;
            if (h_d != '1) state_d = S_LOCKED;
          end else begin
            match_d = match_q + 1'b1;
          end
        end
        S_LOCKED: begin
          // Shifting the prediction keeps one flipped bit to one error.
          h_d    = {h_q[N-1:1], pred};
          chk_ev = 1'b1;
          miss   = (in != pred);
          if (miss && werr_q == ERR_LAST) begin
            state_d = S_FILL;
            fill_d  = '0;
            match_d = '0;
            win_d   = '0;
            werr_d  = '0;
          end else if (win_q == WIN_LAST) begin
            win_d  = '0;
            werr_d = '0;
          end else begin
            win_d  = win_q + 1'b1;
            werr_d = werr_q + EW'(miss);
          end
        end
        default: state_d = S_FILL;
      endcase
    end
  end

  // Output next values: lock flag, error pulse and statistics counters.
  always_comb begin
    locked_d  = (state_d == S_LOCKED);
    err_d     = miss;
    err_cnt_d = stat_next(err_cnt_q, clr, miss);
    bit_cnt_d = stat_next(bit_cnt_q, clr, chk_ev);
  end

  // Registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      locked_q  <= 1'b0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
      bit_cnt_q <= '0;
    end else begin
      locked_q  <= locked_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

  assign locked  = locked_q;
  assign err     = err_q;
  assign err_cnt = err_cnt_q;
  assign bit_cnt = bit_cnt_q;

endmodule

// File: tb/tb_rnd_chk_m.sv
// Bench for rnd_chk_m: RndGen31 stream source with injected bit flips,
// per-cycle {locked, err} scoreboard plus counter checks.
module tb_rnd_chk_m;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_b, clr;
  logic        locked, err;
  logic [31:0] err_cnt, bit_cnt;

  int n_chk = 0;
  int n_err = 0;

  typedef struct {
    logic       ck;
    logic [1:0] ex;
  } sb_t;
  sb_t sb[$];
  sb_t e;

  logic [31:1] g;

  always #5 clk = ~clk;

  rnd_chk_m dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in(in_b), .clr(clr),
    .locked(locked), .err(err), .err_cnt(err_cnt), .bit_cnt(bit_cnt)
  );

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Generator: b[n] = xnor(b[n-31], b[n-28]), g[1] newest.
  function automatic logic gen_next();
    logic b;
    b = ~(g[31] ^ g[28]);
    g = {g[30:1], b};
    return b;
  endfunction

  task automatic cyc(input logic v, input logic b, input logic r,
                     input logic c, input logic ck, input logic [1:0] ex);
    sb_t s;
    @(negedge clk);
    rst = r; clr = c; in_valid = v; in_b = b;
    s.ck = ck; s.ex = ex;
    sb.push_back(s);
  endtask

  task automatic beat(input logic flip, input logic exl, input logic exe);
    logic b;
    b = gen_next() ^ flip;
    cyc(1'b1, b, 1'b0, 1'b0, 1'b1, {exl, exe});
  endtask

  task automatic do_reset();
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00);
  endtask

  // Monitor: one scoreboard entry per driven cycle, compared after the edge.
  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      if (e.ck) check("locked_err", {62'd0, locked, err}, {62'd0, e.ex});
    end
  end

  initial begin
    int lk, nf, v;
    logic f, b;
    rst = 1'b1; clr = 1'b0; in_valid = 1'b0; in_b = 1'b0;
    g = 31'h1234567;

    // Reset state
    do_reset();
    check("rst_locked", {63'd0, locked}, 64'd0);
    check("rst_err", {63'd0, err}, 64'd0);
    check("rst_err_cnt", {32'd0, err_cnt}, 64'd0);
    check("rst_bit_cnt", {32'd0, bit_cnt}, 64'd0);

    // Initial lock after 95 beats, then 10000 clean beats
    for (int i = 1; i <= 95; i++) beat(1'b0, i >= 95, 1'b0);
    for (int i = 0; i < 10000; i++) beat(1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10);
    check("clean_err_cnt", {32'd0, err_cnt}, 64'd0);
    check("clean_bit_cnt", {32'd0, bit_cnt}, 64'd10000);
    lk = 10000;

    // Single flipped bit
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'b10);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10);
    check("clr_bit_cnt", {32'd0, bit_cnt}, 64'd0);
    for (int i = 0; i < 50; i++) beat(i == 20, 1'b1, i == 20);
    lk += 50;
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10);
    check("one_err_cnt", {32'd0, err_cnt}, 64'd1);
    check("one_bit_cnt", {32'd0, bit_cnt}, 64'd50);

    // Align to a window start, then 16 errors in 128 beats
    while (lk % 256 != 0) begin
      beat(1'b0, 1'b1, 1'b0);
      lk++;
    end
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'b10);
    nf = 0;
    for (int i = 0; i < 128; i++) begin
      f = (i % 8 == 7);
      nf += int'(f);
      beat(f, nf < 16, f);
    end
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00);
    check("unlock_err_cnt", {32'd0, err_cnt}, 64'd16);
    check("unlock_locked", {63'd0, locked}, 64'd0);
    for (int j = 1; j <= 95; j++) beat(1'b0, j >= 95, 1'b0);
    for (int j = 0; j < 20; j++) beat(1'b0, 1'b1, 1'b0);

    // Reset while locked
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'b00);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00);
    check("mid_rst_locked", {63'd0, locked}, 64'd0);
    check("mid_rst_err_cnt", {32'd0, err_cnt}, 64'd0);
    check("mid_rst_bit_cnt", {32'd0, bit_cnt}, 64'd0);
    for (int j = 1; j <= 95; j++) beat(1'b0, j >= 95, 1'b0);

    // clr coincident with an error
    beat(1'b1, 1'b1, 1'b1);
    beat(1'b0, 1'b1, 1'b0);
    beat(1'b1, 1'b1, 1'b1);
    b = gen_next() ^ 1'b1;
    cyc(1'b1, b, 1'b0, 1'b1, 1'b1, 2'b11);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10);
    check("clr_err_err_cnt", {32'd0, err_cnt}, 64'd1);
    check("clr_err_bit_cnt", {32'd0, bit_cnt}, 64'd1);

    // Stuck-high line never locks
    do_reset();
    for (int i = 0; i < 1000; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00);
    check("stuck_locked", {63'd0, locked}, 64'd0);
    check("stuck_err_cnt", {32'd0, err_cnt}, 64'd0);

    // 30% valid duty
    do_reset();
    v = 0;
    for (int t = 0; t < 20000 && v < 395; t++) begin
      if ($urandom_range(0, 99) < 30) begin
        v++;
        b = gen_next();
        cyc(1'b1, b, 1'b0, 1'b0, 1'b1, {v >= 95, 1'b0});
      end else begin
        cyc(1'b0, 1'($urandom), 1'b0, 1'b0, 1'b1, {v >= 95, 1'b0});
      end
    end
    check("duty_beats", 64'(v), 64'd395);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10);
    check("duty_err_cnt", {32'd0, err_cnt}, 64'd0);
    check("duty_bit_cnt", {32'd0, bit_cnt}, 64'd300);
    check("duty_locked", {63'd0, locked}, 64'd1);

    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
